// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial two's-complement adder/subtractor.
// Processes DIGIT bits per cycle over NDIG = WIDTH/DIGIT cycles. A registered
// carry links one digit to the next. Reports carry/borrow, signed overflow and
// zero, with a valid/ready handshake on both sides.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for operands, in_ready high (except while in reset)
// BUSY  | one digit per cycle, least significant digit first
// DONE  | result and flags held, out_valid high until out_ready
module addsub_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

  generate
    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("addsub_serial: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   accept;
  logic   last_dig;

  // Operand shift registers. b is stored already inverted for subtraction,
  // so the digit adder only ever adds.
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;   // digits remaining after the current one
  logic             carry_out_q, overflow_q, zero_q;

  logic [DIGIT-1:0] a_dig, b_dig, s_dig;
  logic             c_dig;
  logic             c_into_top;
  logic [WIDTH-1:0] sum_ext, res_next;

  assign a_dig = a_q[DIGIT-1:0];
  assign b_dig = b_q[DIGIT-1:0];
  assign {c_dig, s_dig} = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
  // Carry into the top bit of this digit, recovered from its sum bit. Only
  // meaningful on the last digit, where it is the carry into bit WIDTH-1.
  assign c_into_top = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ s_dig[DIGIT-1];

  // New digit enters at the top; after NDIG shifts every digit sits in place.
  assign sum_ext  = WIDTH'(s_dig);
  assign res_next = (res_q >> DIGIT) | (sum_ext << (WIDTH - DIGIT));

  assign last_dig = (state_q == BUSY) && (cnt_q == '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs. in_ready is gated by rst so the block
  // refuses operands for the whole reset pulse, not just after the first edge.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) begin
          accept  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, digit-serial add, and flag capture on the last digit
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      carry_q <= sub;
      cnt_q   <= LAST_CNT;
    end else if (state_q == BUSY) begin
      a_q     <= a_q >> DIGIT;
      b_q     <= b_q >> DIGIT;
      carry_q <= c_dig;
      res_q   <= res_next;
      if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
      if (last_dig) begin
        carry_out_q <= c_dig;
        overflow_q  <= c_into_top ^ c_dig;
        zero_q      <= (res_next == '0);
      end
    end
  end

  assign result    = res_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Testbench for addsub_serial: a DIGIT=4 instance for the directed cases and
// a DIGIT=16 instance for the bulk reference-model comparison.
module tb_addsub_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        iv4, ir4, sub4, ov4, or4, co4, vf4, z4;
  logic [15:0] a4, b4, r4;
  logic        iv16, ir16, sub16, ov16, or16, co16, vf16, z16;
  logic [15:0] a16, b16, r16;

  addsub_serial #(.WIDTH(16), .DIGIT(4)) u_dig4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .sub(sub4), .out_valid(ov4), .out_ready(or4), .result(r4),
    .carry_out(co4), .overflow(vf4), .zero(z4)
  );

  addsub_serial #(.WIDTH(16), .DIGIT(16)) u_dig16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .sub(sub16), .out_valid(ov16), .out_ready(or16), .result(r16),
    .carry_out(co16), .overflow(vf16), .zero(z16)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] res;
  logic        c, v, z;
  int          lat;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents one operation to the DIGIT=4 instance and waits (bounded) for
  // out_valid. Returns observed values; callers compare them.
  task automatic run_op4(input logic [15:0] a_in, input logic [15:0] b_in,
                         input logic s_in, input bit scramble,
                         output logic [15:0] r_o, output logic c_o,
                         output logic v_o, output logic z_o, output int lat_o);
    iv4  = 1'b1;
    a4   = a_in;
    b4   = b_in;
    sub4 = s_in;
    tick;
    iv4   = 1'b0;
    lat_o = 0;
    while (!ov4 && lat_o < 50) begin
      if (scramble) begin
        a4   = ~a4;
        b4   = 16'($urandom);
        sub4 = ~sub4;
      end
      tick;
      lat_o++;
    end
    r_o = r4;
    c_o = co4;
    v_o = vf4;
    z_o = z4;
  endtask

  task automatic consume4;
    or4 = 1'b1;
    tick;
    or4 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    iv4 = 1'b0; or4 = 1'b0; a4 = '0; b4 = '0; sub4 = 1'b0;
    iv16 = 1'b0; or16 = 1'b0; a16 = '0; b16 = '0; sub16 = 1'b0;
    tick;
    tick;
    n_checks++;
    if ({ir4, ov4, r4, co4, vf4, z4} !== 21'd0)
      $display("FAIL reset_state4: got ir=%b ov=%b r=%h c=%b v=%b z=%b want all 0",
               ir4, ov4, r4, co4, vf4, z4);
    else n_pass++;
    n_checks++;
    if ({ir16, ov16, r16} !== 18'd0)
      $display("FAIL reset_state16: got ir=%b ov=%b r=%h want all 0", ir16, ov16, r16);
    else n_pass++;
    rst = 1'b0;
    tick;
    n_checks++;
    if ({ir4, ov4, ir16, ov16} !== 4'b1010)
      $display("FAIL reset_release: got ir4=%b ov4=%b ir16=%b ov16=%b want 1 0 1 0",
               ir4, ov4, ir16, ov16);
    else n_pass++;
  endtask

  task automatic test_sub_basic;
    run_op4(16'h1234, 16'h0034, 1'b1, 1'b0, res, c, v, z, lat);
    n_checks++;
    if ({res, c, v, z} !== {16'h1200, 1'b1, 1'b0, 1'b0})
      $display("FAIL sub_basic: got r=%h c=%b v=%b z=%b want r=1200 c=1 v=0 z=0", res, c, v, z);
    else n_pass++;
    n_checks++;
    if (lat !== 4) $display("FAIL sub_latency: got %0d want 4", lat);
    else n_pass++;
    consume4;
    n_checks++;
    if ({ov4, ir4} !== 2'b01)
      $display("FAIL sub_handshake: got ov=%b ir=%b want ov=0 ir=1", ov4, ir4);
    else n_pass++;
  endtask

  task automatic test_sub_edges;
    run_op4(16'h0000, 16'h0001, 1'b1, 1'b0, res, c, v, z, lat);
    n_checks++;
    if ({res, c, v, z} !== {16'hFFFF, 1'b0, 1'b0, 1'b0})
      $display("FAIL sub_0_minus_1: got r=%h c=%b v=%b z=%b want r=ffff c=0 v=0 z=0", res, c, v, z);
    else n_pass++;
    consume4;
    run_op4(16'h8000, 16'h0001, 1'b1, 1'b0, res, c, v, z, lat);
    n_checks++;
    if ({res, c, v, z} !== {16'h7FFF, 1'b1, 1'b1, 1'b0})
      $display("FAIL sub_min_minus_1: got r=%h c=%b v=%b z=%b want r=7fff c=1 v=1 z=0", res, c, v, z);
    else n_pass++;
    consume4;
  endtask

  task automatic test_add_edges;
    run_op4(16'h7FFF, 16'h0001, 1'b0, 1'b0, res, c, v, z, lat);
    n_checks++;
    if ({res, c, v, z} !== {16'h8000, 1'b0, 1'b1, 1'b0})
      $display("FAIL add_max_plus_1: got r=%h c=%b v=%b z=%b want r=8000 c=0 v=1 z=0", res, c, v, z);
    else n_pass++;
    consume4;
    run_op4(16'hFFFF, 16'h0001, 1'b0, 1'b0, res, c, v, z, lat);
    n_checks++;
    if ({res, c, v, z} !== {16'h0000, 1'b1, 1'b0, 1'b1})
      $display("FAIL add_wrap_zero: got r=%h c=%b v=%b z=%b want r=0000 c=1 v=0 z=1", res, c, v, z);
    else n_pass++;
    consume4;
  endtask

  task automatic test_backpressure;
    run_op4(16'h1111, 16'h2222, 1'b0, 1'b0, res, c, v, z, lat);
    n_checks++;
    if ({ov4, res, c, v, z} !== {1'b1, 16'h3333, 1'b0, 1'b0, 1'b0})
      $display("FAIL bp_result: got ov=%b r=%h c=%b v=%b z=%b want ov=1 r=3333 c=0 v=0 z=0",
               ov4, res, c, v, z);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      iv4  = 1'b1;
      a4   = 16'($urandom);
      b4   = 16'($urandom);
      sub4 = i[0];
      tick;
      n_checks++;
      if ({ov4, ir4, r4, co4, vf4, z4} !== {1'b1, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0})
        $display("FAIL bp_hold cycle %0d: got ov=%b ir=%b r=%h c=%b v=%b z=%b want ov=1 ir=0 r=3333 c=0 v=0 z=0",
                 i, ov4, ir4, r4, co4, vf4, z4);
      else n_pass++;
    end
    iv4 = 1'b0;
    consume4;
    n_checks++;
    if ({ov4, ir4} !== 2'b01)
      $display("FAIL bp_release: got ov=%b ir=%b want ov=0 ir=1", ov4, ir4);
    else n_pass++;
    tick;
    tick;
    n_checks++;
    if ({ov4, ir4} !== 2'b01)
      $display("FAIL bp_no_queue: got ov=%b ir=%b want ov=0 ir=1", ov4, ir4);
    else n_pass++;
  endtask

  task automatic test_reset_mid_op;
    bit seen;
    iv4 = 1'b1; a4 = 16'h1234; b4 = 16'h1111; sub4 = 1'b0;
    tick;
    iv4 = 1'b0;
    tick;
    rst = 1'b1;
    or4 = 1'b1;
    tick;
    n_checks++;
    if ({ov4, ir4, r4} !== 18'd0)
      $display("FAIL midrst_state: got ov=%b ir=%b r=%h want ov=0 ir=0 r=0000", ov4, ir4, r4);
    else n_pass++;
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (ov4) seen = 1'b1;
    end
    or4 = 1'b0;
    n_checks++;
    if ({seen, ir4} !== 2'b01)
      $display("FAIL midrst_discard: got out_valid_seen=%b ir=%b want 0 1", seen, ir4);
    else n_pass++;
    run_op4(16'h0005, 16'h0005, 1'b1, 1'b1, res, c, v, z, lat);
    n_checks++;
    if ({res, c, v, z} !== {16'h0000, 1'b1, 1'b0, 1'b1})
      $display("FAIL midrst_sub_scrambled: got r=%h c=%b v=%b z=%b want r=0000 c=1 v=0 z=1", res, c, v, z);
    else n_pass++;
    n_checks++;
    if (lat !== 4) $display("FAIL midrst_latency: got %0d want 4", lat);
    else n_pass++;
    consume4;
  endtask

  task automatic test_digit16;
    logic [15:0] ea, eb, bx, er;
    logic        es, ec, ev, ez, cm;
    time         t_first, t_last;
    or16    = 1'b1;
    t_first = 0;
    t_last  = 0;
    for (int k = 0; k < 1000; k++) begin
      ea = 16'($urandom);
      eb = 16'($urandom);
      es = 1'($urandom_range(0, 1));
      if (k == 0) begin ea = 16'h8000; eb = 16'h8000; es = 1'b0; end
      bx = es ? ~eb : eb;
      {ec, er} = {1'b0, ea} + {1'b0, bx} + {16'd0, es};
      cm = ea[15] ^ bx[15] ^ er[15];
      ev = cm ^ ec;
      ez = (er == 16'd0);
      iv16 = 1'b1; a16 = ea; b16 = eb; sub16 = es;
      @(posedge clk);
      if (k == 0) t_first = $time;
      t_last = $time;
      #1;
      iv16 = 1'b0;
      a16  = ~ea;
      sub16 = ~es;
      n_checks++;
      if ({ov16, ir16} !== 2'b00)
        $display("FAIL d16_busy op %0d: got ov=%b ir=%b want 0 0", k, ov16, ir16);
      else n_pass++;
      tick;
      n_checks++;
      if ({ov16, r16, co16, vf16, z16} !== {1'b1, er, ec, ev, ez})
        $display("FAIL d16_result op %0d a=%h b=%h sub=%b: got ov=%b r=%h c=%b v=%b z=%b want ov=1 r=%h c=%b v=%b z=%b",
                 k, ea, eb, es, ov16, r16, co16, vf16, z16, er, ec, ev, ez);
      else n_pass++;
      tick;
      n_checks++;
      if ({ov16, ir16} !== 2'b01)
        $display("FAIL d16_consumed op %0d: got ov=%b ir=%b want 0 1", k, ov16, ir16);
      else n_pass++;
    end
    or16 = 1'b0;
    n_checks++;
    if ((t_last - t_first) !== time'(999 * 3 * 10))
      $display("FAIL d16_throughput: got %0t between first and last accept want %0d",
               t_last - t_first, 999 * 3 * 10);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_sub_basic;
    test_sub_edges;
    test_add_edges;
    test_backpressure;
    test_reset_mid_op;
    test_digit16;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks done", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
